// File: rtl/module_mux_arbiter.sv
// module_mux_arbiter: two-requester round-robin arbiter feeding a 4-bit 2:1 mux
// into a one-entry valid/ready output register, with a bounded burst per owner.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_1/in_1/ack_1      requester 1 handshake and data
//   req_2/in_2/ack_2      requester 2 handshake and data
//   sel                   mux select (0 = in_1, 1 = in_2)
//   out_valid/out_ready   output register handshake
//   out_data              registered output word
//   busy                  out_valid | req_1 | req_2

module module_mux_21 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in_2 : in_1;

endmodule

module module_mux_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_1,
  input  logic [WIDTH-1:0] in_1,
  output logic             ack_1,
  input  logic             req_2,
  input  logic [WIDTH-1:0] in_2,
  output logic             ack_2,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic             owner;
  logic [3:0]       burst_cnt;
  logic             load_en;
  logic             xfer;
  logic             win;
  logic [WIDTH-1:0] mux_out;

  always_comb begin
    load_en = !out_valid || out_ready;
    // rst_n gates the transfer so acks stay low while held in reset
    xfer    = rst_n && load_en && (req_1 || req_2);
    win     = 1'b0;
    unique case (1'b1)
      (req_1 && req_2):
        win = (burst_cnt < MAX_B) ? owner : ~owner;
      (req_2 && !req_1):
        win = 1'b1;
      default:
        win = 1'b0;
    endcase
    sel   = xfer ? win : owner;
    ack_1 = xfer && !win;
    ack_2 = xfer && win;
  end

  assign busy = out_valid || req_1 || req_2;

  module_mux_21 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in_1 (in_1),
    .in_2 (in_2),
    .sel  (sel),
    .out  (mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      owner     <= 1'b0;
      burst_cnt <= 4'd0;
    end else if (xfer) begin
      out_data  <= mux_out;
      out_valid <= 1'b1;
      if (win != owner) begin
        owner     <= win;
        burst_cnt <= 4'd1;
      end else if (burst_cnt < MAX_B) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end else if (load_en) begin
      // idle slot: the current run is over
      burst_cnt <= 4'd0;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_module_mux_arbiter.sv
// tb_module_mux_arbiter: directed stimulus with a grant-history model
// checked every cycle, plus literal expectations at key points.

module tb_module_mux_arbiter;

  localparam int MB = 4;

  logic       clk;
  logic       rst_n;
  logic       req_1;
  logic [3:0] in_1;
  logic       ack_1;
  logic       req_2;
  logic [3:0] in_2;
  logic       ack_2;
  logic       sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [3:0] q_out[$];
  int         hist[$];
  int         g[$];

  module_mux_arbiter #(
    .WIDTH     (4),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_1     (req_1),
    .in_1      (in_1),
    .ack_1     (ack_1),
    .req_2     (req_2),
    .in_2      (in_2),
    .ack_2     (ack_2),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // owner = most recent grantee; idle markers (-1) do not change it
  function automatic int m_owner();
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i] >= 0) return hist[i];
    return 0;
  endfunction

  // length of the current unbroken run of grants to the owner
  function automatic int m_run(input int own);
    int c = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != own) break;
      c++;
    end
    return c;
  endfunction

  function automatic int pack();
    int v = 0;
    foreach (g[i]) v = (v << 1) | g[i];
    return v;
  endfunction

  always @(negedge clk) begin
    int own, run, win;
    bit ld, x;
    if (!rst_n) begin
      q_out.delete();
      hist.delete();
    end
    own = m_owner();
    run = m_run(own);
    ld  = (q_out.size() == 0) || out_ready;
    x   = rst_n && ld && (req_1 || req_2);
    if (req_1 && req_2) win = (run < MB) ? own : 1 - own;
    else win = req_2 ? 1 : 0;
    chk("ack_1", int'(ack_1), int'(x && win == 0));
    chk("ack_2", int'(ack_2), int'(x && win == 1));
    chk("sel", int'(sel), x ? win : own);
    chk("out_valid", int'(out_valid), int'(q_out.size() == 1));
    chk("busy", int'(busy), int'(q_out.size() == 1 || req_1 || req_2));
    if (q_out.size() == 1) chk("out_data", int'(out_data), int'(q_out[0]));
    if (ack_1) g.push_back(0);
    else if (ack_2) g.push_back(1);
    if (rst_n) begin
      if (x) begin
        q_out.delete();
        q_out.push_back(win == 1 ? in_2 : in_1);
        hist.push_back(win);
      end else if (ld) begin
        if (out_ready) q_out.delete();
        hist.push_back(-1);
      end
    end
  end

  task automatic set_in(input logic r1, input logic [3:0] d1,
                        input logic r2, input logic [3:0] d2,
                        input logic rdy);
    req_1 = r1;
    in_1 = d1;
    req_2 = r2;
    in_2 = d2;
    out_ready = rdy;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1, 4'h5, 1, 4'hE, 1);
    step(2);
    chk("rst_ack_1", int'(ack_1), 0);
    chk("rst_ack_2", int'(ack_2), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 1);

    rst_n = 1'b1;
    g.delete();
    step(12);
    chk("cont_cnt", g.size(), 12);
    chk("cont_grants", pack(), 'b000011110000);
    chk("cont_data", int'(out_data), 5);

    set_in(0, 0, 0, 0, 1);
    step(1);
    chk("idle_valid", int'(out_valid), 0);
    chk("idle_busy", int'(busy), 0);

    set_in(1, 4'h5, 0, 0, 1);
    #1;
    chk("s1_ack", int'(ack_1), 1);
    chk("s1_sel", int'(sel), 0);
    step(1);
    set_in(0, 0, 1, 4'hE, 1);
    #1;
    chk("s2_ack", int'(ack_2), 1);
    chk("s2_sel", int'(sel), 1);
    chk("s1_data", int'(out_data), 5);
    step(1);
    chk("s2_data", int'(out_data), 14);

    set_in(1, 4'h5, 0, 0, 1);
    step(1);
    set_in(0, 0, 1, 4'hE, 0);
    repeat (3) begin
      #1;
      chk("bp_ack", int'(ack_2), 0);
      chk("bp_data", int'(out_data), 5);
      step(1);
    end
    set_in(0, 0, 1, 4'hE, 1);
    #1;
    chk("bp_rel_ack", int'(ack_2), 1);
    step(1);
    chk("bp_rel_data", int'(out_data), 14);

    set_in(0, 0, 0, 0, 1);
    step(1);
    set_in(1, 4'h5, 0, 0, 1);
    step(2);
    set_in(0, 0, 0, 0, 1);
    step(1);
    g.delete();
    set_in(1, 4'h5, 1, 4'hE, 1);
    step(5);
    chk("burst_cnt", g.size(), 5);
    chk("burst_grants", pack(), 'b00001);

    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_ack", int'(ack_1 | ack_2), 0);
    chk("arst_sel", int'(sel), 0);
    step(1);
    rst_n = 1'b1;
    g.delete();
    #1;
    chk("post_ack_1", int'(ack_1), 1);
    step(3);
    chk("post_cnt", g.size(), 3);
    chk("post_grants", pack(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
